sram_1rw_masked_init: RTL and testbench
=======================================

// Module: sram_1rw_masked_init
// PURPOSE
//   Parametrised single-port (1RW) byte-lane-masked SRAM with a valid/ready request port,
//   registered read data held until the next read, and a hardware clear sequencer.
//   The sequencer writes INIT_VAL to every word after reset or on request.
//   Next-generation replacement for the fixed-size *_ext array macros, used by cache
//   tag/data arrays that need a known power-on state without a software clear loop.
// PARAMETERS
//   DEPTH      4096  number of words; any value >= 2 (need not be a power of two)
//   WIDTH      64    bits per word
//   MASK_GRAN  16    bits per write-mask lane; WIDTH % MASK_GRAN must be 0 (elaboration error otherwise)
//   INIT_VAL   0     WIDTH-bit value written to every word by the clear sequence
//   (derived)  AW = $clog2(DEPTH), MS = WIDTH/MASK_GRAN
// PORTS
//   RW0_clk        in   1      clock; all state is on posedge
//   RW0_rst_n      in   1      asynchronous active-low reset
//   RW0_req_valid  in   1      request present
//   RW0_req_ready  out  1      request accepted when valid&&ready
//   RW0_wmode      in   1      1=write, 0=read
//   RW0_addr       in   AW     word address; values >= DEPTH are ignored (write dropped, read returns 0)
//   RW0_wmask      in   MS     lane i writes wdata[i*MASK_GRAN +: MASK_GRAN]
//   RW0_wdata      in   WIDTH  write data
//   RW0_rvalid     out  1      one-cycle pulse: RW0_rdata updated with read result
//   RW0_rdata      out  WIDTH  last read result, held stable between reads
//   init_start     in   1      pulse: re-run the clear sequence (honoured only in IDLE)
//   init_done      out  1      1 = clear complete, array usable
// BEHAVIOUR
//   - Reset (async assert, sync release): state=INIT, cnt=0, req_ready=0, rvalid=0,
//     rdata=0, init_done=0. Array contents are not reset; INIT overwrites them.
//   - States: INIT, IDLE.
//     INIT: each cycle writes INIT_VAL (all lanes) to ram[cnt], then cnt++.
//       The cycle that writes cnt==DEPTH-1 moves to IDLE and sets init_done=1 next edge.
//       Clear takes exactly DEPTH cycles after reset release.
//     IDLE: init_start=1 -> INIT, cnt=0, init_done=0. A read in flight still completes.
//   - req_ready = (state==IDLE) && !init_start. init_start wins over a same-cycle request.
//     That request is not accepted; the requester holds it until INIT ends.
//   - Requests in INIT are never accepted; valid may stay high without side effects.
//   - Write accept: masked lanes of ram[addr] are updated at that edge. No rvalid. rdata unchanged.
//     wmask==0 is a legal no-op.
//   - Read accept: rdata=ram[addr] and rvalid=1 one cycle later (latency 1).
//     Back-to-back reads are accepted every cycle, one result per cycle.
//   - Read accepted the cycle after a write to the same address returns the new data.
//   - rdata holds its value through writes, idle cycles and INIT. Only reset clears it to 0.
//   - Reset asserted mid-INIT or mid-read: drop the read (no rvalid) and restart INIT from cnt=0.
//   - No X may reach rdata after reset, including for out-of-range addresses.
// CONFIGURATION
//   SRAM_RDATA_REG_EN defined: add one output register stage.
//     rdata/rvalid arrive 2 cycles after accept and stay aligned with each other.
//     Throughput is still 1 read/cycle. The hold rule applies to the final stage.
//     The reset value of both stages is 0.
//   Undefined: latency 1 as above; no extra flops.
// TESTING
//   1 DEPTH=16, WIDTH=64, MASK_GRAN=16, INIT_VAL=64'hA5A5_A5A5_A5A5_A5A5, release reset.
//     -> req_ready=0 for 16 cycles, init_done=1 on cycle 16; reads of addr 0..15 all return A5A5...
//   2 Write addr 3, wdata=64'h1111_2222_3333_4444, wmask=4'b0101, then read addr 3
//     -> rvalid 1 cycle later, rdata=64'hA5A5_2222_A5A5_4444
//   3 Reads of addr 1, 2, 3 issued back-to-back -> three consecutive rvalid pulses in order.
//     rdata then holds the addr-3 value while 5 idle cycles and a write to addr 1 pass.
//   4 init_start and a read request in the same IDLE cycle -> req_ready=0, init_done drops,
//     16 clear cycles follow; the held read is accepted after INIT and returns INIT_VAL.
//   5 Reset asserted at cnt=7 during INIT -> outputs return to reset values at once;
//     after release the clear takes the full 16 cycles.
//   6 Rerun tests 1-3 with SRAM_RDATA_REG_EN defined -> identical data with 2-cycle read latency;
//     also read addr 20 (out of range) -> rdata=0.

Source files
------------

// File: rtl/sram_1rw_masked_init.sv
// Single-port byte-lane-masked SRAM with a valid/ready request port, held read data
// and a hardware clear sequencer that writes INIT_VAL to every word.
// Optional build macro: SRAM_RDATA_REG_EN adds one output register stage (read latency 2).
module sram_1rw_masked_init #(
    parameter int unsigned      DEPTH     = 4096,
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      MASK_GRAN = 16,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0,
    localparam int unsigned     AW        = $clog2(DEPTH),
    localparam int unsigned     MS        = WIDTH / MASK_GRAN
) (
    input  logic             RW0_clk,
    input  logic             RW0_rst_n,
    input  logic             RW0_req_valid,
    output logic             RW0_req_ready,
    input  logic             RW0_wmode,
    input  logic [AW-1:0]    RW0_addr,
    input  logic [MS-1:0]    RW0_wmask,
    input  logic [WIDTH-1:0] RW0_wdata,
    output logic             RW0_rvalid,
    output logic [WIDTH-1:0] RW0_rdata,
    input  logic             init_start,
    output logic             init_done
);

    if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("WIDTH must be a multiple of MASK_GRAN");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("DEPTH must be at least 2");
    end

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StInit, StIdle} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             init_done_q, init_done_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             in_range;
    logic             rd_fire;
    logic             wr_fire;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // init_start steals the port so a same-cycle request waits for the clear to finish
    assign RW0_req_ready = (state_q == StIdle) && !init_start;
    assign rd_fire       = RW0_req_valid && RW0_req_ready && !RW0_wmode;
    assign wr_fire       = RW0_req_valid && RW0_req_ready && RW0_wmode;
    assign in_range      = (32'(RW0_addr) < DEPTH);
    // Out-of-range reads return zero so no X can reach rdata
    assign rd_word       = in_range ? mem[RW0_addr] : '0;
    assign init_done     = init_done_q;

    // Clear sequencer next-state: walk every word once, then serve requests
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                if (init_start) begin
                    state_d     = StInit;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Sequencer state register; reset restarts the clear from word 0
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Array write port: the sequencer owns it in INIT, masked lane writes otherwise
    always_ff @(posedge RW0_clk) begin
        if (state_q == StInit) begin
            mem[cnt_q] <= INIT_VAL;
        end else if (wr_fire && in_range) begin
            for (int i = 0; i < MS; i++) begin
                if (RW0_wmask[i]) begin
                    mem[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // First read stage: capture on an accepted read, hold otherwise
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_fire;
            if (rd_fire) begin
                rdata_q <= rd_word;
            end
        end
    end

`ifdef SRAM_RDATA_REG_EN
    logic [WIDTH-1:0] rdata_out_q;
    logic             rvalid_out_q;

    // Output stage: data moves only alongside its valid, so the held value stays put
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            rdata_out_q  <= '0;
            rvalid_out_q <= 1'b0;
        end else begin
            rvalid_out_q <= rvalid_q;
            if (rvalid_q) begin
                rdata_out_q <= rdata_q;
            end
        end
    end

    assign RW0_rdata  = rdata_out_q;
    assign RW0_rvalid = rvalid_out_q;
`else
    assign RW0_rdata  = rdata_q;
    assign RW0_rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
// Directed self-checking bench for sram_1rw_masked_init (both read-latency builds).
module tb_sram_1rw_masked_init;

`ifdef SRAM_RDATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [63:0] IV  = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [15:0] OIV = 16'h5A3C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, wmode, rvalid, init_start, init_done;
    logic [3:0]  addr, wmask;
    logic [63:0] wdata, rdata;

    // Second instance: non-power-of-two depth to reach out-of-range addresses
    logic        o_valid, o_ready, o_wmode, o_rvalid, o_start, o_done;
    logic [4:0]  o_addr;
    logic [1:0]  o_wmask;
    logic [15:0] o_wdata, o_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_1rw_masked_init #(
        .DEPTH(16), .WIDTH(64), .MASK_GRAN(16), .INIT_VAL(IV)
    ) u_dut (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_req_valid(req_valid),
        .RW0_req_ready(req_ready), .RW0_wmode(wmode), .RW0_addr(addr),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rvalid(rvalid), .RW0_rdata(rdata),
        .init_start(init_start), .init_done(init_done)
    );

    sram_1rw_masked_init #(
        .DEPTH(18), .WIDTH(16), .MASK_GRAN(8), .INIT_VAL(OIV)
    ) u_dut_odd (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_req_valid(o_valid),
        .RW0_req_ready(o_ready), .RW0_wmode(o_wmode), .RW0_addr(o_addr),
        .RW0_wmask(o_wmask), .RW0_wdata(o_wdata), .RW0_rvalid(o_rvalid), .RW0_rdata(o_rdata),
        .init_start(o_start), .init_done(o_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one read for one accept edge, then wait until its result is visible
    task automatic issue_read(input logic [3:0] a);
        req_valid = 1'b1; wmode = 1'b0; addr = a;
        step();
        req_valid = 1'b0;
        repeat (LAT - 1) step();
    endtask

    task automatic issue_write(input logic [3:0] a, input logic [63:0] d, input logic [3:0] m);
        req_valid = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m;
        step();
        req_valid = 1'b0; wmode = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", req_ready); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got %b want 0", rvalid); end
        total++; if (rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", rdata); end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", init_done); end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            total++;
            if ({init_done, req_ready} !== {2{k == 16}}) begin
                bad++;
                $display("FAIL init_len cycle %0d got done/ready %b%b want %b", k, init_done,
                         req_ready, k == 16);
            end
        end
    endtask

    task automatic test_init_values();
        for (int a = 0; a < 16; a++) begin
            issue_read(4'(a));
            total++;
            if ({rvalid, rdata} !== {1'b1, IV}) begin
                bad++;
                $display("FAIL init_val addr %0d got %b/%h want 1/%h", a, rvalid, rdata, IV);
            end
        end
        step();
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_pulse got %b want 0", rvalid); end
    endtask

    task automatic test_masked_write();
        issue_write(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000);
        issue_write(4'd3, 64'h1111_2222_3333_4444, 4'b0101);
        total++;
        if ({rvalid, rdata} !== {1'b0, IV}) begin
            bad++; $display("FAIL write_no_rvalid got %b/%h want 0/%h", rvalid, rdata, IV);
        end
        issue_read(4'd3);
        total++;
        if ({rvalid, rdata} !== {1'b1, 64'hA5A5_2222_A5A5_4444}) begin
            bad++; $display("FAIL masked_rd got %b/%h want 1/a5a52222a5a54444", rvalid, rdata);
        end
        issue_read(4'd5);
        total++;
        if (rdata !== IV) begin bad++; $display("FAIL mask0_noop got %h want %h", rdata, IV); end
        issue_write(4'd2, 64'h0123_4567_89AB_CDEF, 4'b1111);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  seq [3];
        logic [63:0] exp [3];
        int idx;
        seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd3;
        exp[0] = IV; exp[1] = 64'h0123_4567_89AB_CDEF; exp[2] = 64'hA5A5_2222_A5A5_4444;
        for (int s = 1; s <= 3 + LAT; s++) begin
            if (s <= 3) begin
                req_valid = 1'b1; wmode = 1'b0; addr = seq[s-1];
            end else begin
                req_valid = 1'b0;
            end
            step();
            idx = s - LAT;
            total++;
            if (idx >= 0 && idx <= 2) begin
                if ({rvalid, rdata} !== {1'b1, exp[idx]}) begin
                    bad++;
                    $display("FAIL b2b slot %0d got %b/%h want 1/%h", idx, rvalid, rdata, exp[idx]);
                end
            end else if (rvalid !== 1'b0) begin
                bad++; $display("FAIL b2b gap step %0d got rvalid %b want 0", s, rvalid);
            end
        end
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if ({rvalid, rdata} !== {1'b0, exp[2]}) begin
                bad++; $display("FAIL hold_idle %0d got %b/%h want 0/%h", k, rvalid, rdata, exp[2]);
            end
        end
        issue_write(4'd1, 64'hDEAD_BEEF_DEAD_BEEF, 4'b1111);
        for (int k = 0; k <= LAT; k++) begin
            total++;
            if ({rvalid, rdata} !== {1'b0, exp[2]}) begin
                bad++; $display("FAIL hold_write %0d got %b/%h want 0/%h", k, rvalid, rdata, exp[2]);
            end
            step();
        end
        issue_read(4'd1);
        total++;
        if (rdata !== 64'hDEAD_BEEF_DEAD_BEEF) begin
            bad++; $display("FAIL write_full got %h want deadbeefdeadbeef", rdata);
        end
    endtask

    task automatic test_init_start();
        init_start = 1'b1; req_valid = 1'b1; wmode = 1'b0; addr = 4'd3;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL start_ready got %b want 0", req_ready); end
        step();
        init_start = 1'b0;
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL start_done got %b want 0", init_done); end
        for (int k = 1; k <= 16; k++) begin
            step();
            total++;
            if ({init_done, req_ready, rvalid} !== {{2{k == 16}}, 1'b0}) begin
                bad++;
                $display("FAIL reinit cycle %0d got done/ready/rvalid %b%b%b want %b%b0", k,
                         init_done, req_ready, rvalid, k == 16, k == 16);
            end
        end
        step();
        req_valid = 1'b0;
        repeat (LAT - 1) step();
        total++;
        if ({rvalid, rdata} !== {1'b1, IV}) begin
            bad++; $display("FAIL held_read got %b/%h want 1/%h", rvalid, rdata, IV);
        end
    endtask

    task automatic test_reset_mid_init();
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rvalid, rdata, init_done, req_ready} !== {1'b0, 64'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_rst got rvalid %b rdata %h done %b ready %b want all 0",
                     rvalid, rdata, init_done, req_ready);
        end
        step(); step();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            total++;
            if ({init_done, req_ready} !== {2{k == 16}}) begin
                bad++;
                $display("FAIL restart_len cycle %0d got done/ready %b%b want %b", k, init_done,
                         req_ready, k == 16);
            end
        end
        issue_read(4'd7);
        total++;
        if (rdata !== IV) begin bad++; $display("FAIL after_rst got %h want %h", rdata, IV); end
    endtask

    task automatic test_out_of_range();
        repeat (4) step();
        total++; if (o_done !== 1'b1) begin bad++; $display("FAIL odd_done got %b want 1", o_done); end
        o_valid = 1'b1; o_wmode = 1'b0; o_addr = 5'd17;
        step();
        o_valid = 1'b0;
        repeat (LAT - 1) step();
        total++;
        if ({o_rvalid, o_rdata} !== {1'b1, OIV}) begin
            bad++; $display("FAIL odd_last got %b/%h want 1/%h", o_rvalid, o_rdata, OIV);
        end
        o_valid = 1'b1; o_addr = 5'd20;
        step();
        o_valid = 1'b0;
        repeat (LAT - 1) step();
        total++;
        if ({o_rvalid, o_rdata} !== {1'b1, 16'h0}) begin
            bad++; $display("FAIL oor_read got %b/%h want 1/0000", o_rvalid, o_rdata);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;
        init_start = 1'b0;
        o_valid = 1'b0; o_wmode = 1'b0; o_addr = '0; o_wmask = '0; o_wdata = '0; o_start = 1'b0;
        test_reset();
        test_init_values();
        test_masked_write();
        test_back_to_back();
        test_init_start();
        test_reset_mid_init();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
